// File: rtl/wb_bram_arbiter.sv
// Two-master Wishbone arbiter sharing one single-port BRAM slave.
// The grant is held for a master's whole cyc; contested requests alternate round-robin.
module wb_bram_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    output logic [DATA_WIDTH-1:0]   m0_dat_o,
    input  logic                    m0_we_i,
    input  logic [SELECT_WIDTH-1:0] m0_sel_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_cyc_i,
    output logic                    m0_ack_o,

    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    output logic [DATA_WIDTH-1:0]   m1_dat_o,
    input  logic                    m1_we_i,
    input  logic [SELECT_WIDTH-1:0] m1_sel_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_cyc_i,
    output logic                    m1_ack_o,

    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    output logic                    s_we_o,
    output logic [SELECT_WIDTH-1:0] s_sel_o,
    output logic                    s_stb_o,
    output logic                    s_cyc_o,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,
    input  logic                    s_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state, state_next;
    logic   last, last_next;
    logic   gnt0, gnt1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            last  <= last_next;
        end
    end

    // When both request from IDLE, the master that was not served last wins.
    always_comb begin
        state_next = state;
        last_next  = last;
        case (state)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last)) begin
                    state_next = GNT0;
                    last_next  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_next = GNT1;
                    last_next  = 1'b1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) state_next = IDLE;
            end
            GNT1: begin
                if (!m1_cyc_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign gnt0 = (state == GNT0);
    assign gnt1 = (state == GNT1);

    // Mux select depends only on the registered grant, never on live requests.
    assign s_adr_o  = gnt1 ? m1_adr_i : m0_adr_i;
    assign s_dat_o  = gnt1 ? m1_dat_i : m0_dat_i;
    assign s_we_o   = gnt1 ? m1_we_i  : m0_we_i;
    assign s_sel_o  = gnt1 ? m1_sel_i : m0_sel_i;
    assign s_cyc_o  = (m0_cyc_i & gnt0) | (m1_cyc_i & gnt1);
    assign s_stb_o  = (m0_stb_i & gnt0) | (m1_stb_i & gnt1);

    assign m0_ack_o = s_ack_i & gnt0;
    assign m1_ack_o = s_ack_i & gnt1;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// Bench for wb_bram_arbiter: behavioural 1-cycle-ack BRAM slave, two master drivers,
// per-master expected-response queues drained by a negedge monitor.
module tb_wb_bram_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] m0_adr = '0, m1_adr = '0;
    logic [DW-1:0] m0_dat = '0, m1_dat = '0;
    logic          m0_we = 1'b0, m1_we = 1'b0;
    logic [SW-1:0] m0_sel = '0, m1_sel = '0;
    logic          m0_stb = 1'b0, m1_stb = 1'b0;
    logic          m0_cyc = 1'b0, m1_cyc = 1'b0;
    logic [DW-1:0] m0_dat_o, m1_dat_o;
    logic          m0_ack_o, m1_ack_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic          s_we_o, s_stb_o, s_cyc_o;
    logic [SW-1:0] s_sel_o;
    logic [DW-1:0] bram_dat = '0;
    logic          bram_ack = 1'b0;
    logic [DW-1:0] mem [256];

    typedef struct {
        logic          chk;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp0[$];
    exp_t exp1[$];
    int   ack_log[$];
    int   checks = 0;
    int   failures = 0;

    wb_bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we),
        .m0_sel_i(m0_sel), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(m0_ack_o),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we),
        .m1_sel_i(m1_sel), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(m1_ack_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(bram_dat), .s_ack_i(bram_ack)
    );

    always #5 clk = ~clk;

    // Slave model: its ack is deliberately not reset, so a pending ack survives an arbiter reset.
    always @(posedge clk) begin
        bram_ack <= s_cyc_o & s_stb_o & ~bram_ack;
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[0] <= 32'h0101_0101;
            mem[1] <= 32'hDEAD_BEEF;
            mem[3] <= 32'h3333_3333;
        end else if (s_cyc_o && s_stb_o && !bram_ack) begin
            bram_dat <= mem[s_adr_o[9:2]];
            if (s_we_o) begin
                for (int b = 0; b < SW; b++)
                    if (s_sel_o[b]) mem[s_adr_o[9:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
            end
        end
    end

    function automatic void score(input int m, input logic [DW-1:0] dat);
        exp_t e;
        checks++;
        ack_log.push_back(m);
        if ((m == 1 && exp1.size() == 0) || (m == 0 && exp0.size() == 0)) begin
            failures++;
            $display("[TB] FAIL unexpected_ack m%0d: got ack with data %08h, required no ack", m, dat);
            return;
        end
        if (m == 1) e = exp1.pop_front();
        else        e = exp0.pop_front();
        if (e.chk && dat !== e.data) begin
            failures++;
            $display("[TB] FAIL read_data m%0d: got %08h, required %08h", m, dat, e.data);
        end
    endfunction

    always @(negedge clk) begin
        if (m0_ack_o === 1'b1 && m1_ack_o === 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL dual_ack: got both acks high, required at most one");
        end
        if (m0_ack_o === 1'b1) score(0, m0_dat_o);
        if (m1_ack_o === 1'b1) score(1, m1_dat_o);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp_v);
        end
    endtask

    task automatic set_bus(input int m, input logic cyc, input logic stb, input logic we,
                           input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic [SW-1:0] sel);
        if (m == 1) begin
            m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_dat = dat; m1_sel = sel;
        end else begin
            m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_dat = dat; m0_sel = sel;
        end
    endtask

    function automatic logic ack_of(input int m);
        return (m == 1) ? m1_ack_o : m0_ack_o;
    endfunction

    // One cyc of 'beats' strobed accesses at consecutive words; expected read data per beat in expv.
    task automatic applyStimulus(input int m, input logic we, input logic [AW-1:0] adr,
                                 input logic [DW-1:0] dat, input logic [SW-1:0] sel,
                                 input int beats, input logic [3:0][DW-1:0] expv);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        for (int i = 0; i < beats; i++) begin
            set_bus(m, 1'b1, 1'b1, we, adr + AW'(4 * i), dat, sel);
            e.chk  = !we;
            e.data = expv[i];
            if (m == 1) exp1.push_back(e);
            else        exp0.push_back(e);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (ack_of(m) !== 1'b1 && n < 100);
            if (ack_of(m) !== 1'b1) begin
                checks++;
                failures++;
                $display("[TB] FAIL ack_timeout m%0d: got no ack, required ack within 100 cycles", m);
            end
            @(posedge clk); #1;
        end
        set_bus(m, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic check_order(input string name, input int n, input logic [7:0] bits);
        checkOutput({name, "_count"}, 32'(ack_log.size()), 32'(n));
        for (int i = 0; i < n && i < ack_log.size(); i++)
            checkOutput(name, 32'(ack_log[i]), {31'b0, bits[i]});
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        $display("[TB] reset with m0 requesting");
        set_bus(0, 1'b1, 1'b1, 1'b0, 10'h004, '0, 4'hF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_s_cyc", 32'(s_cyc_o), 32'd0);
        checkOutput("reset_s_stb", 32'(s_stb_o), 32'd0);
        checkOutput("reset_m0_ack", 32'(m0_ack_o), 32'd0);
        #1;
        set_bus(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] m0 single read of 0x004 with cycle timing");
        @(posedge clk); #1;
        set_bus(0, 1'b1, 1'b1, 1'b0, 10'h004, '0, 4'hF);
        exp0.push_back('{chk: 1'b1, data: 32'hDEAD_BEEF});
        @(negedge clk);
        checkOutput("t1_stb_before_grant", 32'(s_stb_o), 32'd0);
        @(negedge clk);
        checkOutput("t1_stb_after_grant", 32'(s_stb_o), 32'd1);
        checkOutput("t1_ack_not_yet", 32'(m0_ack_o), 32'd0);
        @(negedge clk);
        checkOutput("t1_m0_ack", 32'(m0_ack_o), 32'd1);
        checkOutput("t1_m1_ack", 32'(m1_ack_o), 32'd0);
        @(posedge clk); #1;
        set_bus(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        checkOutput("t1_ack_single_pulse", 32'(m0_ack_o), 32'd0);
        checkOutput("t1_idle_after_release", 32'(s_cyc_o), 32'd0);

        $display("[TB] simultaneous first request after reset");
        do_reset();
        ack_log.delete();
        fork
            applyStimulus(0, 1'b1, 10'h008, 32'h1122_3344, 4'hF, 1, '0);
            applyStimulus(1, 1'b0, 10'h008, '0, 4'hF, 1, {96'h0, 32'h1122_3344});
        join
        check_order("t2_order", 2, 8'b0000_0010);

        $display("[TB] m1 four-beat read holds grant while m0 waits");
        ack_log.delete();
        fork
            applyStimulus(1, 1'b0, 10'h000, '0, 4'hF, 4,
                          {32'h3333_3333, 32'h1122_3344, 32'hDEAD_BEEF, 32'h0101_0101});
            begin
                repeat (2) @(posedge clk);
                applyStimulus(0, 1'b0, 10'h004, '0, 4'hF, 1, {96'h0, 32'hDEAD_BEEF});
            end
        join
        check_order("t3_order", 5, 8'b0000_1111);

        $display("[TB] byte-select write by m0, readback by m1");
        applyStimulus(0, 1'b1, 10'h010, 32'hAABB_CCDD, 4'b0010, 1, '0);
        applyStimulus(1, 1'b0, 10'h010, '0, 4'hF, 1, {96'h0, 32'h0000_CC00});

        $display("[TB] continuous contention over six transactions");
        ack_log.delete();
        fork
            repeat (3) applyStimulus(0, 1'b0, 10'h000, '0, 4'hF, 1, {96'h0, 32'h0101_0101});
            repeat (3) applyStimulus(1, 1'b0, 10'h00C, '0, 4'hF, 1, {96'h0, 32'h3333_3333});
        join
        check_order("t4_order", 6, 8'b0010_1010);

        $display("[TB] reset during m1 access with ack pending");
        ack_log.delete();
        @(posedge clk); #1;
        set_bus(1, 1'b1, 1'b1, 1'b0, 10'h000, '0, 4'hF);
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t5_s_cyc_after_reset", 32'(s_cyc_o), 32'd0);
        checkOutput("t5_s_stb_after_reset", 32'(s_stb_o), 32'd0);
        checkOutput("t5_m1_ack_dropped", 32'(m1_ack_o), 32'd0);
        #1;
        set_bus(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        check_order("t5_no_ack", 0, 8'b0);
        fork
            applyStimulus(0, 1'b0, 10'h004, '0, 4'hF, 1, {96'h0, 32'hDEAD_BEEF});
            applyStimulus(1, 1'b0, 10'h00C, '0, 4'hF, 1, {96'h0, 32'h3333_3333});
        join
        check_order("t5_order", 2, 8'b0000_0010);

        repeat (3) @(posedge clk);
        checkOutput("exp0_drained", 32'(exp0.size()), 32'd0);
        checkOutput("exp1_drained", 32'(exp1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, required finish within 500000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/wb_bram_arbiter.md
# wb_bram_arbiter

Two-master Wishbone arbiter that shares one single-port `wb_bram` instance between an instruction-fetch master (m0) and a data master (m1). It grants the slave port to one master for the full duration of that master's `cyc` and uses round-robin priority when both request. Grant is registered, and slave-side strobes are gated by it. Multi-beat cycles (`cyc` held, several `stb`/`ack`) pass through unbroken.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data bus width in bits (8/16/32/64).
- `ADDR_WIDTH`, 10, byte address width, identical on all three ports.
- `SELECT_WIDTH`, `DATA_WIDTH/8`, byte-select width.

Ports (`x` ∈ {0,1}):
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `mx_adr_i`  in  ADDR_WIDTH  master x address.
- `mx_dat_i`  in  DATA_WIDTH  master x write data.
- `mx_dat_o`  out  DATA_WIDTH  read data to master x; both masters receive `s_dat_i` unconditionally.
- `mx_we_i`  in  1  master x write enable.
- `mx_sel_i`  in  SELECT_WIDTH  master x byte selects.
- `mx_stb_i`  in  1  master x strobe.
- `mx_cyc_i`  in  1  master x cycle.
- `mx_ack_o`  out  1  ack to master x.
- `s_adr_o`  out  ADDR_WIDTH  to slave.
- `s_dat_o`  out  DATA_WIDTH  to slave.
- `s_we_o`  out  1  to slave.
- `s_sel_o`  out  SELECT_WIDTH  to slave.
- `s_stb_o`  out  1  to slave.
- `s_cyc_o`  out  1  to slave.
- `s_dat_i`  in  DATA_WIDTH  from slave.
- `s_ack_i`  in  1  from slave.

## Operation
- Registered state: FSM `state` ∈ {IDLE, GNT0, GNT1}; `last` (1 bit, master served most recently).
- Reset (`rst_n`=0 at an edge): `state`←IDLE, `last`←1, so m0 wins the first contested arbitration.
- IDLE transitions:
  - Only `m0_cyc_i` high → GNT0.
  - Only `m1_cyc_i` high → GNT1.
  - Both high → grant the master ≠ `last`.
  - Neither high → stay in IDLE.
  - On entering GNTx, `last`←x.
- GNTx: stay while `mx_cyc_i`=1. On `mx_cyc_i`=0 → IDLE. There is no direct GNT0↔GNT1 hop; one IDLE cycle always separates grants.
- The other master's `cyc` is never preempted. A master that holds `cyc` indefinitely starves the other; this is by design.
- Output muxing is combinational from `state` only, never from requests:
  - GNT1 selects m1's `adr`/`dat`/`we`/`sel`. IDLE and GNT0 select m0's.
  - `s_cyc_o` = `mx_cyc_i` & (state==GNTx); 0 in IDLE.
  - `s_stb_o` = `mx_stb_i` & (state==GNTx); 0 in IDLE.
  - `mx_ack_o` = `s_ack_i` & (state==GNTx). In IDLE, a stray `s_ack_i` is dropped.
- `stb` may toggle within a held `cyc`; each `stb` pulse reaches the slave while the grant is held.
- Reset mid-transaction: the in-flight access is abandoned. `s_cyc_o`/`s_stb_o` are 0 from the first cycle after the reset edge. A slave ack arriving in that cycle reaches neither master.

## Timing
- All outputs are combinational from registered `state` plus inputs. There is no combinational path from `mx_cyc_i` to another master's outputs.
- Grant latency: request seen in IDLE at edge N → GNTx after edge N; slave strobe visible in cycle N+1.
- With `wb_bram` (1-cycle ack), a single access from idle acks at cycle N+2: 2 cycles from `cyc` assertion to ack.
- Release: master drops `cyc` in cycle M → IDLE after edge M → the other master's grant after edge M+1.
- Simultaneous first request of both masters out of reset → m0 first, then m1.
- Back-to-back contention alternates m0, m1, m0, …

## Test plan
- Reset, then m0 single read of address 0x004 (BRAM preloaded 0xDEADBEEF) → `s_stb_o` high one cycle after `cyc`; `m0_ack_o` pulses exactly one cycle; `m0_dat_o`=0xDEADBEEF; `m1_ack_o` stays 0.
- Both masters assert `cyc`/`stb` on the same edge after reset: m0 writes 0x11223344 to 0x008, m1 reads 0x008 → m0 served first; m1 granted 1 cycle after m0 drops `cyc`; m1 reads 0x11223344.
- m1 holds `cyc` over 4 strobed reads (0x000–0x00C) while m0 requests → m0 sees no ack until m1 releases; m1 receives 4 acks with correct data.
- Continuous contention over 6 transactions → grant order m0, m1, m0, m1, m0, m1; each grant preceded by one IDLE cycle.
- `rst_n` low for one edge during an m1 access with ack pending → `s_cyc_o`=0 the next cycle; no ack delivered to m1; next contested request goes to m0.
- m0 write with `sel`=4'b0010, data 0xAABBCCDD, to a word holding 0 → BRAM word reads back 0x0000CC00 via m1.
